cpu_mc: RTL and testbench

- Parametrised multicycle successor to the single-cycle accumulator CPU top.
- Harvard core: 16-bit instructions from a synchronous instruction ROM, N-bit data through a req/ack data-memory port that allows wait states.
- Four N-bit general registers; Switches input; registered LED output; WAIT-on-Go stall; HALT.
- Sits at the top of the board design. Instantiates no RAM itself: the ROM and RAM attach externally.

---
 rtl/cpu_mc.sv | 207 ++++++++++++++++++++
 tb/tb_cpu_mc.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mc.sv
// Multicycle Harvard accumulator-style CPU: 16-bit instructions from a synchronous ROM,
// N-bit data through a req/ack memory port, four registers, switches/LEDs, WAIT and HALT.
module cpu_mc #(
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic          Clock,
    input  logic          nReset,
    output logic [AW-1:0] IAddr,
    input  logic [15:0]   IData,
    output logic [AW-1:0] DAddr,
    output logic [N-1:0]  DWData,
    input  logic [N-1:0]  DRData,
    output logic          DReq,
    output logic          DWe,
    input  logic          DAck,
    input  logic [N-1:0]  Switches,
    input  logic          Go,
    output logic [N-1:0]  LEDs,
    output logic          Halted
);

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_LD   = 4'h6;
    localparam logic [3:0] OP_ST   = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_BZ   = 4'hB;
    localparam logic [3:0] OP_BC   = 4'hC;
    localparam logic [3:0] OP_WAIT = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hE;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WAIT,
        S_HALT
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]     pc;
    logic [15:0]       ir;
    logic [3:0][N-1:0] regs;
    logic              zf, cf;
    logic              go_s1, go_s2, go_s3, go_pulse;

    logic [3:0]    op;
    logic [1:0]    rd, rs;
    logic [7:0]    imm;
    logic [N-1:0]  rd_val, rs_val, imm_n;
    logic [AW-1:0] imm_a, pc_inc;
    logic [N:0]    alu_res;
    logic          wb_en, c_en, br_taken;

    // Result in [N-1:0], carry/borrow in [N]; only ADD/SUB give a meaningful top bit.
    function automatic logic [N:0] alu(input logic [3:0]   f,
                                       input logic [N-1:0] a,
                                       input logic [N-1:0] b,
                                       input logic [N-1:0] k,
                                       input logic [N-1:0] sw);
        logic [N:0] r;
        case (f)
            OP_LDI:  r = {1'b0, k};
            OP_ADD:  r = {1'b0, a} + {1'b0, b};
            OP_SUB:  r = {1'b0, a} - {1'b0, b};
            OP_AND:  r = {1'b0, a & b};
            OP_OR:   r = {1'b0, a | b};
            OP_IN:   r = {1'b0, sw};
            default: r = {1'b0, a};
        endcase
        return r;
    endfunction

    function automatic logic branch_taken(input logic [3:0] f, input logic z, input logic c);
        return (f == OP_JMP) || ((f == OP_BZ) && z) || ((f == OP_BC) && c);
    endfunction

    assign op     = ir[15:12];
    assign rd     = ir[11:10];
    assign rs     = ir[9:8];
    assign imm    = ir[7:0];
    assign rd_val = regs[rd];
    assign rs_val = regs[rs];
    assign imm_n  = N'(imm);
    assign imm_a  = AW'(imm);
    assign pc_inc = pc + AW'(1);
    assign IAddr  = pc;

    always_comb begin
        alu_res  = alu(op, rd_val, rs_val, imm_n, Switches);
        wb_en    = (op == OP_LDI) || (op == OP_ADD) || (op == OP_SUB) ||
                   (op == OP_AND) || (op == OP_OR)  || (op == OP_IN);
        c_en     = (op == OP_ADD) || (op == OP_SUB);
        br_taken = branch_taken(op, zf, cf);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (IData[15:12])
                    OP_LD, OP_ST: state_nxt = S_MEM;
                    OP_WAIT:      state_nxt = S_WAIT;
                    OP_HALT:      state_nxt = S_HALT;
                    default:      state_nxt = S_EXEC;
                endcase
            end
            S_EXEC:   state_nxt = S_FETCH;
            S_MEM:    if (DAck) state_nxt = S_FETCH;
            S_WAIT:   if (go_pulse) state_nxt = S_FETCH;
            S_HALT:   state_nxt = S_HALT;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // Strobes decode straight from state so that an async reset drops DReq at once.
    always_comb begin
        DReq   = (state == S_MEM);
        DWe    = (state == S_MEM) && (op == OP_ST);
        Halted = (state == S_HALT);
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            pc     <= '0;
            ir     <= '0;
            regs   <= '0;
            zf     <= 1'b0;
            cf     <= 1'b0;
            LEDs   <= '0;
            DAddr  <= '0;
            DWData <= '0;
        end else begin
            case (state)
                S_DECODE: begin
                    ir <= IData;
                    // Latch the memory operands here so they sit still for every wait cycle.
                    if ((IData[15:12] == OP_LD) || (IData[15:12] == OP_ST)) begin
                        DAddr  <= AW'(IData[7:0]);
                        DWData <= regs[IData[11:10]];
                    end
                end
                S_EXEC: begin
                    if (wb_en) begin
                        regs[rd] <= alu_res[N-1:0];
                        zf       <= (alu_res[N-1:0] == '0);
                    end
                    if (c_en) begin
                        cf <= alu_res[N];
                    end
                    if (op == OP_OUT) begin
                        LEDs <= rd_val;
                    end
                    pc <= br_taken ? imm_a : pc_inc;
                end
                S_MEM: begin
                    if (DAck) begin
                        if (op == OP_LD) begin
                            regs[rd] <= DRData;
                            zf       <= (DRData == '0);
                        end
                        pc <= pc_inc;
                    end
                end
                S_WAIT: begin
                    if (go_pulse) begin
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Go synchroniser and edge detector run continuously; pulses outside WAIT are dropped.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            go_s1 <= 1'b0;
            go_s2 <= 1'b0;
            go_s3 <= 1'b0;
        end else begin
            go_s1 <= Go;
            go_s2 <= go_s1;
            go_s3 <= go_s2;
        end
    end

    assign go_pulse = go_s2 & ~go_s3;

endmodule

// File: tb/tb_cpu_mc.sv
// Directed self-checking bench for cpu_mc with a tb-side instruction ROM and a wait-state data RAM.
module tb_cpu_mc;

    logic        Clock = 1'b0;
    logic        nReset = 1'b0;
    logic [7:0]  IAddr;
    logic [15:0] IData = 16'h0000;
    logic [7:0]  DAddr;
    logic [7:0]  DWData;
    logic [7:0]  DRData;
    logic        DReq;
    logic        DWe;
    logic        DAck;
    logic [7:0]  Switches = 8'h00;
    logic        Go = 1'b0;
    logic [7:0]  LEDs;
    logic        Halted;

    int checks = 0;
    int passes = 0;

    logic [15:0] rom [256];
    logic [7:0]  ram [256];
    int          wcnt = 0;
    int          txn = 0;
    int          d0 = 0;
    int          d1 = 0;
    logic        mem_clr = 1'b0;
    logic        ack_force = 1'b0;

    cpu_mc #(.N(8), .AW(8)) dut (
        .Clock(Clock), .nReset(nReset), .IAddr(IAddr), .IData(IData),
        .DAddr(DAddr), .DWData(DWData), .DRData(DRData), .DReq(DReq),
        .DWe(DWe), .DAck(DAck), .Switches(Switches), .Go(Go),
        .LEDs(LEDs), .Halted(Halted)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) IData <= rom[IAddr];

    assign DRData = ram[DAddr];
    assign DAck   = ack_force | (DReq && (wcnt == ((txn == 0) ? d0 : d1)));

    always @(posedge Clock) begin
        if (mem_clr) begin
            wcnt <= 0;
            txn  <= 0;
        end else if (DReq && DAck) begin
            wcnt <= 0;
            txn  <= txn + 1;
            if (DWe) ram[DAddr] <= DWData;
        end else if (DReq) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [1:0] rd,
                                        input logic [1:0] rs, input logic [7:0] imm);
        return {op, rd, rs, imm};
    endfunction

    task automatic rom_clear();
        for (int i = 0; i < 256; i++) rom[i] = 16'hE000;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic do_reset();
        nReset  = 1'b0;
        mem_clr = 1'b1;
        step(2);
        nReset  = 1'b1;
        mem_clr = 1'b0;
    endtask

    task automatic wait_halt(input int budget, output int cyc);
        cyc = 0;
        while (!Halted && cyc < budget) begin
            @(negedge Clock);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rom_clear();
        nReset = 1'b0;
        step(3);
        checks++; if (IAddr !== 8'h00) $display("FAIL reset_iaddr got %h want 00", IAddr); else passes++;
        checks++; if (LEDs !== 8'h00) $display("FAIL reset_leds got %h want 00", LEDs); else passes++;
        checks++; if ({DReq, DWe, Halted} !== 3'b000)
            $display("FAIL reset_strobes got %b want 000", {DReq, DWe, Halted}); else passes++;
        checks++; if ({DAddr, DWData} !== 16'h0000)
            $display("FAIL reset_dport got %h want 0000", {DAddr, DWData}); else passes++;
    endtask

    task automatic test_basic();
        int cyc;
        rom_clear();
        rom[0] = ins(4'h1, 2'd0, 2'd0, 8'h05);
        rom[1] = ins(4'h1, 2'd1, 2'd0, 8'h03);
        rom[2] = ins(4'h2, 2'd0, 2'd1, 8'h00);
        rom[3] = ins(4'h9, 2'd0, 2'd0, 8'h00);
        rom[4] = ins(4'hE, 2'd0, 2'd0, 8'h00);
        do_reset();
        wait_halt(40, cyc);
        checks++; if (Halted !== 1'b1 || cyc > 15)
            $display("FAIL basic_halt halted=%b cycles=%0d want 1 within 15", Halted, cyc); else passes++;
        checks++; if (LEDs !== 8'h08) $display("FAIL basic_leds got %h want 08", LEDs); else passes++;
        step(3);
        checks++; if (IAddr !== 8'h04) $display("FAIL basic_pc_frozen got %h want 04", IAddr); else passes++;
    endtask

    task automatic test_branch();
        int cyc;
        rom_clear();
        rom[8'h00] = ins(4'h1, 2'd3, 2'd0, 8'h5A);
        rom[8'h01] = ins(4'h9, 2'd3, 2'd0, 8'h00);
        rom[8'h02] = ins(4'h1, 2'd0, 2'd0, 8'hFF);
        rom[8'h03] = ins(4'h1, 2'd1, 2'd0, 8'h01);
        rom[8'h04] = ins(4'h2, 2'd0, 2'd1, 8'h00);
        rom[8'h05] = ins(4'hB, 2'd0, 2'd0, 8'h20);
        rom[8'h20] = ins(4'hC, 2'd0, 2'd0, 8'h30);
        rom[8'h30] = ins(4'h9, 2'd0, 2'd0, 8'h00);
        rom[8'h31] = ins(4'h1, 2'd2, 2'd0, 8'h01);
        rom[8'h32] = ins(4'hB, 2'd0, 2'd0, 8'h40);
        do_reset();
        step(17);
        checks++; if (IAddr !== 8'h05) $display("FAIL br_before got %h want 05", IAddr); else passes++;
        checks++; if (LEDs !== 8'h5A) $display("FAIL br_leds_5a got %h want 5a", LEDs); else passes++;
        step(1);
        checks++; if (IAddr !== 8'h20) $display("FAIL bz_taken got %h want 20", IAddr); else passes++;
        step(3);
        checks++; if (IAddr !== 8'h30) $display("FAIL bc_taken got %h want 30", IAddr); else passes++;
        wait_halt(60, cyc);
        checks++; if (Halted !== 1'b1 || IAddr !== 8'h33)
            $display("FAIL bz_not_taken halted=%b iaddr=%h want 1/33", Halted, IAddr); else passes++;
        checks++; if (LEDs !== 8'h00) $display("FAIL br_r0_zero got %h want 00", LEDs); else passes++;
    endtask

    task automatic test_alu();
        int cyc;
        rom_clear();
        rom[8'h00] = ins(4'h1, 2'd0, 2'd0, 8'h03);
        rom[8'h01] = ins(4'h1, 2'd1, 2'd0, 8'h05);
        rom[8'h02] = ins(4'h3, 2'd0, 2'd1, 8'h00);
        rom[8'h03] = ins(4'h9, 2'd0, 2'd0, 8'h00);
        rom[8'h04] = ins(4'hC, 2'd0, 2'd0, 8'h10);
        rom[8'h10] = ins(4'h1, 2'd2, 2'd0, 8'hF0);
        rom[8'h11] = ins(4'h1, 2'd3, 2'd0, 8'h3C);
        rom[8'h12] = ins(4'h4, 2'd2, 2'd3, 8'h00);
        rom[8'h13] = ins(4'h3, 2'd2, 2'd2, 8'h00);
        rom[8'h14] = ins(4'hC, 2'd0, 2'd0, 8'h40);
        rom[8'h15] = ins(4'hB, 2'd0, 2'd0, 8'h20);
        rom[8'h20] = ins(4'h5, 2'd3, 2'd1, 8'h00);
        rom[8'h21] = ins(4'h9, 2'd3, 2'd0, 8'h00);
        do_reset();
        step(12);
        checks++; if (LEDs !== 8'hFE) $display("FAIL sub_wrap got %h want fe", LEDs); else passes++;
        wait_halt(80, cyc);
        checks++; if (Halted !== 1'b1 || IAddr !== 8'h22)
            $display("FAIL alu_path halted=%b iaddr=%h want 1/22", Halted, IAddr); else passes++;
        checks++; if (LEDs !== 8'h3D) $display("FAIL or_result got %h want 3d", LEDs); else passes++;
    endtask

    task automatic test_mem();
        int n, hi, cyc;
        logic stable;
        rom_clear();
        rom[0] = ins(4'h1, 2'd2, 2'd0, 8'hA5);
        rom[1] = ins(4'h7, 2'd2, 2'd0, 8'h10);
        rom[2] = ins(4'h6, 2'd3, 2'd0, 8'h10);
        rom[3] = ins(4'h9, 2'd3, 2'd0, 8'h00);
        d0 = 3;
        d1 = 0;
        do_reset();
        n = 0;
        while (!DReq && n < 20) begin @(negedge Clock); n++; end
        checks++; if (DReq !== 1'b1) $display("FAIL st_req got %b want 1", DReq); else passes++;
        hi = 0;
        stable = 1'b1;
        while (DReq && hi < 20) begin
            if (DAddr !== 8'h10 || DWe !== 1'b1 || DWData !== 8'hA5) stable = 1'b0;
            hi++;
            @(negedge Clock);
        end
        checks++; if (hi != 4) $display("FAIL st_req_len got %0d want 4", hi); else passes++;
        checks++; if (stable !== 1'b1) $display("FAIL st_stable got %b want 1", stable); else passes++;
        checks++; if (ram[8'h10] !== 8'hA5) $display("FAIL st_data got %h want a5", ram[8'h10]); else passes++;
        n = 0;
        while (!DReq && n < 20) begin @(negedge Clock); n++; end
        checks++; if ({DReq, DWe, DAddr} !== {1'b1, 1'b0, 8'h10})
            $display("FAIL ld_req got %b%b/%h want 10/10", DReq, DWe, DAddr); else passes++;
        hi = 0;
        while (DReq && hi < 20) begin hi++; @(negedge Clock); end
        checks++; if (hi != 1) $display("FAIL ld_req_len got %0d want 1", hi); else passes++;
        wait_halt(40, cyc);
        checks++; if (LEDs !== 8'hA5) $display("FAIL ld_result got %h want a5", LEDs); else passes++;
    endtask

    task automatic test_io_wait();
        int n, cyc;
        rom_clear();
        rom[0] = ins(4'h8, 2'd1, 2'd0, 8'h00);
        rom[1] = ins(4'h9, 2'd1, 2'd0, 8'h00);
        rom[2] = ins(4'hD, 2'd0, 2'd0, 8'h00);
        rom[3] = ins(4'h1, 2'd0, 2'd0, 8'h11);
        rom[4] = ins(4'h9, 2'd0, 2'd0, 8'h00);
        Switches = 8'h3C;
        Go = 1'b0;
        do_reset();
        step(1);
        Go = 1'b1;
        step(2);
        Go = 1'b0;
        step(1);
        Go = 1'b1;
        step(6);
        checks++; if (IAddr !== 8'h02) $display("FAIL wait_entry got %h want 02", IAddr); else passes++;
        checks++; if (LEDs !== 8'h3C) $display("FAIL in_out got %h want 3c", LEDs); else passes++;
        step(10);
        checks++; if (IAddr !== 8'h02 || Halted !== 1'b0)
            $display("FAIL wait_stall iaddr=%h halted=%b want 02/0", IAddr, Halted); else passes++;
        Go = 1'b0;
        step(4);
        checks++; if (IAddr !== 8'h02) $display("FAIL wait_go_low got %h want 02", IAddr); else passes++;
        Go = 1'b1;
        n = 0;
        while (IAddr !== 8'h03 && n < 10) begin @(negedge Clock); n++; end
        checks++; if (IAddr !== 8'h03 || n > 4)
            $display("FAIL wait_release iaddr=%h cycles=%0d want 03 within 4", IAddr, n); else passes++;
        Go = 1'b0;
        wait_halt(40, cyc);
        checks++; if (LEDs !== 8'h11 || IAddr !== 8'h05)
            $display("FAIL wait_resume leds=%h iaddr=%h want 11/05", LEDs, IAddr); else passes++;
        Switches = 8'h00;
    endtask

    task automatic test_wrap();
        rom_clear();
        rom[8'h00] = ins(4'hA, 2'd0, 2'd0, 8'hFF);
        rom[8'hFF] = 16'h0000;
        do_reset();
        step(3);
        checks++; if (IAddr !== 8'hFF) $display("FAIL jmp_ff got %h want ff", IAddr); else passes++;
        step(3);
        checks++; if (IAddr !== 8'h00) $display("FAIL pc_wrap got %h want 00", IAddr); else passes++;
    endtask

    task automatic test_reset_mid_mem();
        int n, cyc;
        rom_clear();
        rom[0] = ins(4'h1, 2'd0, 2'd0, 8'h42);
        rom[1] = ins(4'h1, 2'd1, 2'd0, 8'h01);
        rom[2] = ins(4'h1, 2'd2, 2'd0, 8'h02);
        rom[3] = ins(4'h1, 2'd3, 2'd0, 8'h03);
        rom[4] = ins(4'h9, 2'd0, 2'd0, 8'h00);
        rom[5] = ins(4'h7, 2'd0, 2'd0, 8'h20);
        d0 = 1000;
        d1 = 1000;
        do_reset();
        n = 0;
        while (!DReq && n < 40) begin @(negedge Clock); n++; end
        checks++; if (DReq !== 1'b1 || LEDs !== 8'h42)
            $display("FAIL rst_pre req=%b leds=%h want 1/42", DReq, LEDs); else passes++;
        #2;
        nReset = 1'b0;
        #1;
        checks++; if (DReq !== 1'b0) $display("FAIL rst_async_dreq got %b want 0", DReq); else passes++;
        checks++; if (IAddr !== 8'h00 || LEDs !== 8'h00)
            $display("FAIL rst_async_state iaddr=%h leds=%h want 00/00", IAddr, LEDs); else passes++;
        rom_clear();
        rom[0] = ins(4'h5, 2'd0, 2'd1, 8'h00);
        rom[1] = ins(4'h5, 2'd0, 2'd2, 8'h00);
        rom[2] = ins(4'h5, 2'd0, 2'd3, 8'h00);
        rom[3] = ins(4'hB, 2'd0, 2'd0, 8'h40);
        ack_force = 1'b1;
        mem_clr = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        nReset = 1'b1;
        mem_clr = 1'b0;
        step(3);
        checks++; if (IAddr !== 8'h01 || DReq !== 1'b0)
            $display("FAIL rst_stale_ack iaddr=%h req=%b want 01/0", IAddr, DReq); else passes++;
        ack_force = 1'b0;
        wait_halt(40, cyc);
        checks++; if (Halted !== 1'b1 || IAddr !== 8'h40)
            $display("FAIL rst_regs_zero halted=%b iaddr=%h want 1/40", Halted, IAddr); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_branch();
        test_alu();
        test_mem();
        test_io_wait();
        test_wrap();
        test_reset_mid_mem();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
